seq_detect_param: RTL and testbench

//  Parametrised Mealy serial pattern detector, successor to the fixed 6-bit detector.

---
 rtl/seq_detect_param.sv | 87 ++++++++
 tb/tb_seq_detect_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-loadable Mealy serial pattern detector; SEQ_DETECT_MASK_EN adds a per-bit compare mask
module seq_detect_param #(
    parameter int PAT_W = 6,
    parameter int CNT_W = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(6'b110101),
    parameter int DEF_LEN = 6,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             valid,
    input  logic             d_in,
    input  logic             overlap,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
`ifdef SEQ_DETECT_MASK_EN
    input  logic [PAT_W-1:0] cfg_mask,
`endif
    input  logic             cnt_clr,
    output logic             pattern_detect,
    output logic             armed,
    output logic             cfg_err,
    output logic [CNT_W-1:0] match_count
);
    typedef enum logic {UNARMED, ARMED} state_t;
    state_t state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d, hist_q, hist_d, cand, len_mask, diff;
    logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d, fill_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic cfg_err_q, cfg_err_d, len_ok, hit, clear;
`ifdef SEQ_DETECT_MASK_EN
    logic [PAT_W-1:0] mask_q, mask_d;
`endif
    always_comb begin
        cand     = {hist_q[PAT_W-2:0], d_in};
        len_mask = ~({PAT_W{1'b1}} << len_q);
`ifdef SEQ_DETECT_MASK_EN
        diff     = (cand ^ pat_q) & len_mask & mask_q;
        mask_d   = cfg_load ? cfg_mask : mask_q;
`else
        diff     = (cand ^ pat_q) & len_mask;
`endif
        fill_inc = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
        len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
        // a load cycle wins over the data bit, so it can never complete a match
        hit      = valid & ~cfg_load & ~res & (state_q == ARMED)
                 & (({1'b0, fill_q} + 1'b1) >= {1'b0, len_q}) & (diff == '0);
        clear    = cfg_load | (hit & ~overlap);
        state_d   = cfg_load ? (len_ok ? ARMED : UNARMED) : state_q;
        cfg_err_d = cfg_load ? ~len_ok : cfg_err_q;
        pat_d     = cfg_load ? cfg_pattern : pat_q;
        len_d     = cfg_load ? cfg_len : len_q;
        hist_d    = clear ? '0 : valid ? cand : hist_q;
        fill_d    = clear ? '0 : valid ? fill_inc : fill_q;
        cnt_d     = cnt_clr ? CNT_W'(hit) : (hit && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= ARMED;
            cfg_err_q <= 1'b0;
            pat_q     <= DEF_PAT;
            len_q     <= LEN_W'(DEF_LEN);
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
`ifdef SEQ_DETECT_MASK_EN
            mask_q    <= '1;
`endif
        end else begin
            state_q   <= state_d;
            cfg_err_q <= cfg_err_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
`ifdef SEQ_DETECT_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end
    assign pattern_detect = hit;
    assign armed          = (state_q == ARMED);
    assign cfg_err        = cfg_err_q;
    assign match_count    = cnt_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed vector bench for seq_detect_param (SEQ_DETECT_MASK_EN adds the masked-compare case)
module tb_seq_detect_param;
    localparam int PAT_W = 6;
    localparam int CNT_W = 8;
    localparam int LEN_W = 3;
    typedef struct {
        logic r;
        logic v;
        logic d;
        logic ov;
        logic det;
        int   cnt;
    } vec_t;
    logic clk = 1'b0, res = 1'b0, valid = 1'b0, d_in = 1'b0, overlap = 1'b1;
    logic cfg_load = 1'b0, cnt_clr = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
`ifdef SEQ_DETECT_MASK_EN
    logic [PAT_W-1:0] cfg_mask = '1;
`endif
    logic pattern_detect, armed, cfg_err;
    logic [CNT_W-1:0] match_count;
    int total = 0, bad = 0;
    vec_t tbl[$];
    always #5 clk = ~clk;
    seq_detect_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .res(res), .valid(valid), .d_in(d_in), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
`ifdef SEQ_DETECT_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .cnt_clr(cnt_clr), .pattern_detect(pattern_detect), .armed(armed),
        .cfg_err(cfg_err), .match_count(match_count)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic drv(input logic r, input logic v, input logic d);
        @(negedge clk);
        res = r;
        valid = v;
        d_in = d;
    endtask
    task automatic cyc(input logic r, input logic v, input logic d, input logic det, input string nm);
        drv(r, v, d);
        #2;
        chk(nm, 32'(pattern_detect), 32'(det));
    endtask
    task automatic regs(input string nm, input logic a, input logic e, input int c);
        chk({nm, "_armed"}, 32'(armed), 32'(a));
        chk({nm, "_cfg_err"}, 32'(cfg_err), 32'(e));
        chk({nm, "_count"}, 32'(match_count), 32'(c));
    endtask
    task automatic load(input logic [LEN_W-1:0] l, input logic [PAT_W-1:0] p, input logic d);
        @(negedge clk);
        res = 1'b0;
        cfg_load = 1'b1;
        cfg_len = l;
        cfg_pattern = p;
        valid = 1'b1;
        d_in = d;
        #2;
        chk("load_det", 32'(pattern_detect), 32'd0);
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        valid = 1'b0;
    endtask
    function automatic void add(input logic r, v, d, ov, det, input int cnt);
        tbl.push_back('{r, v, d, ov, det, cnt});
    endfunction
    initial begin
        logic [10:0] s;
        s = 11'b11010110101;
        add(1, 0, 0, 1, 0, -1);
        for (int i = 0; i < 11; i++) add(0, 1, s[10-i], 1, (i == 5 || i == 10), (i > 5) ? 1 : 0);
        add(0, 0, 0, 1, 0, 2);
        add(1, 0, 0, 0, 0, 2);
        for (int i = 0; i < 11; i++) add(0, 1, s[10-i], 0, (i == 5), (i > 5) ? 1 : 0);
        add(0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 1, 0, 1);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 0, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 0, 1, 0, 0);
        add(0, 1, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 1);
        foreach (tbl[i]) begin
            drv(tbl[i].r, tbl[i].v, tbl[i].d);
            overlap = tbl[i].ov;
            #2;
            chk($sformatf("row%0d_det", i), 32'(pattern_detect), 32'(tbl[i].det));
            if (tbl[i].cnt >= 0) chk($sformatf("row%0d_count", i), 32'(match_count), 32'(tbl[i].cnt));
        end
        cyc(1, 0, 0, 0, "rst_det");
        cyc(0, 0, 0, 0, "rst_idle");
        regs("rst", 1, 0, 0);
        overlap = 1'b1;
        load(3, 6'b000101, 1'b1);
        cyc(0, 0, 0, 0, "t4_idle");
        regs("t4_load", 1, 0, 0);
        cyc(0, 1, 1, 0, "t4_b1");
        cyc(0, 1, 0, 0, "t4_b2");
        cyc(0, 1, 1, 1, "t4_b3");
        cyc(0, 1, 0, 0, "t4_b4");
        cyc(0, 1, 1, 1, "t4_b5");
        cyc(0, 1, 0, 0, "t4_b6");
        load(3, 6'b000101, 1'b1);
        cyc(0, 1, 1, 0, "t4_after_load");
        cyc(0, 1, 0, 0, "t4_re_b2");
        cyc(0, 1, 1, 1, "t4_re_b3");
        cyc(0, 0, 0, 0, "t4_idle2");
        regs("t4_cnt", 1, 0, 3);
        load(0, 6'b000101, 1'b1);
        cyc(0, 0, 0, 0, "t4_bad_idle");
        regs("t4_bad", 0, 1, 3);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1'(~i[0]), 0, $sformatf("t4_unarmed_b%0d", i));
        load(7, 6'b000001, 1'b1);
        cyc(0, 1, 1, 0, "t4_len7_b1");
        regs("t4_len7", 0, 1, 3);
        load(1, 6'b000001, 1'b0);
        cyc(0, 1, 1, 1, "t4_len1_b1");
        cyc(0, 1, 0, 0, "t4_len1_b2");
        cyc(0, 1, 1, 1, "t4_len1_b3");
        cyc(0, 0, 0, 0, "t4_len1_idle");
        regs("t4_len1", 1, 0, 5);
        for (int i = 0; i < 250; i++) drv(0, 1, 1);
        cyc(0, 0, 0, 0, "t5_idle");
        regs("t5_full", 1, 0, 255);
        cyc(0, 1, 1, 1, "t5_sat_hit");
        cyc(0, 0, 0, 0, "t5_idle2");
        regs("t5_sat", 1, 0, 255);
        cnt_clr = 1'b1;
        cyc(0, 1, 1, 1, "t5_clr_hit");
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        cyc(0, 0, 0, 0, "t5_idle3");
        regs("t5_clr", 1, 0, 1);
        load(0, 6'b000001, 1'b0);
        cyc(1, 0, 0, 0, "t6_rst_unarmed");
        cyc(0, 0, 0, 0, "t6_idle");
        regs("t6_rst_err", 1, 0, 0);
        load(6, 6'b001011, 1'b0);
        cyc(0, 1, 0, 0, "t6_b1");
        cyc(0, 1, 0, 0, "t6_b2");
        cyc(0, 1, 1, 0, "t6_b3");
        cyc(0, 1, 0, 0, "t6_b4");
        cyc(0, 1, 1, 0, "t6_b5");
        cyc(1, 1, 1, 0, "t6_res_forced");
        cyc(0, 1, 0, 0, "t6_post0");
        regs("t6_rst", 1, 0, 0);
        cyc(0, 1, 1, 0, "t6_post1");
        cyc(0, 1, 1, 0, "t6_def_b1");
        cyc(0, 1, 1, 0, "t6_def_b2");
        cyc(0, 1, 0, 0, "t6_def_b3");
        cyc(0, 1, 1, 0, "t6_def_b4");
        cyc(0, 1, 0, 0, "t6_def_b5");
        cyc(0, 1, 1, 1, "t6_def_b6");
        cyc(0, 0, 0, 0, "t6_idle2");
        regs("t6_def", 1, 0, 1);
`ifdef SEQ_DETECT_MASK_EN
        cyc(1, 0, 0, 0, "t7_rst");
        cfg_mask = 6'b110111;
        load(6, 6'b110101, 1'b0);
        cfg_mask = '1;
        cyc(0, 1, 1, 0, "t7_b1");
        cyc(0, 1, 1, 0, "t7_b2");
        cyc(0, 1, 1, 0, "t7_b3");
        cyc(0, 1, 1, 0, "t7_b4");
        cyc(0, 1, 0, 0, "t7_b5");
        cyc(0, 1, 1, 1, "t7_b6");
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
